rs_word_packer: RTL and testbench
=================================

Name: rs_word_packer

Overview:
- Downstream stage of the RS encoder; sits between the encoder's 8-bit AXIS codeword output and the 32-bit link/DMA side.
- Frames each codeword: an optional 32-bit sync marker (ASM) goes out first, then the codeword bytes packed big-endian into 32-bit words with byte-valid keep.
- Polices codeword length against N_BYTES and resynchronises on tlast errors.

Parameters:
- N_BYTES, 255, codeword length in bytes (n); must be ≥ 1.
- ASM_WORD, 32'h1ACFFC1D, sync marker emitted as the first word of each frame.
- CNT_W, clog2(N_BYTES+1), byte counter width; derived, do not override.

Ports:
- core_clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  8  codeword byte from the RS encoder.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted when tvalid && tready.
- s_axis_tlast  in  1  last byte of codeword.
- m_axis_tdata  out  32  packed word; first byte in [31:24].
- m_axis_tkeep  out  4  byte valid; bit3 ↔ [31:24].
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last word of frame.
- evt_tlast_early  out  1  1-cycle pulse: tlast before byte N_BYTES.
- evt_tlast_missing  out  1  1-cycle pulse: byte N_BYTES accepted without tlast.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, accumulator and counters cleared. A reset mid-frame discards the partial frame.
- Output register: holds one word. `free = !m_axis_tvalid || m_axis_tready`. A word loads only when free is true. tdata, tkeep and tlast stay stable while tvalid && !tready.
- States: IDLE, PACK, DROP.
- IDLE:
  - s_axis_tready = 0.
  - If s_axis_tvalid && free: load ASM_WORD (tkeep=4'hF, tlast=0), clear byte_cnt and acc_cnt, go to PACK.
  - ASM appears on m_axis_tvalid in the next cycle.
- PACK:
  - s_axis_tready = free.
  - Each accepted byte goes into acc at lane 3-acc_cnt; acc_cnt and byte_cnt increment.
  - A word completes when acc_cnt reaches 4 or the frame closes. The completed word loads the output register in the same cycle; unused lanes are 0 and tkeep has the MSB-contiguous mask (1→4'h8, 2→4'hC, 3→4'hE, 4→4'hF).
- Frame close (in PACK, on an accepted byte k = byte_cnt+1):
  - tlast && k == N_BYTES: normal close. tlast on the word, go to IDLE.
  - tlast && k < N_BYTES: close, tlast on the word, pulse evt_tlast_early, go to IDLE.
  - !tlast && k == N_BYTES: force close, tlast on the word, pulse evt_tlast_missing, go to DROP.
- DROP:
  - s_axis_tready = 1; bytes are discarded with no output.
  - On an accepted byte with tlast, go to IDLE.
- Throughput: 1 byte/cycle in; 1 word per 4 accepted bytes out, plus the ASM and partial-word overhead.
- Pulses are registered and last exactly 1 cycle, in the cycle after the offending byte is accepted.
- A 1-byte frame (tlast on the first byte) gives tkeep=4'h8 and evt_tlast_early if N_BYTES > 1.
- N_BYTES divisible by 4: the last word has tkeep=4'hF.
- The byte count never wraps: at most N_BYTES bytes are counted per frame.

Optional Feature:
- Macro RS_PACK_ASM_EN.
  - Defined: ASM_WORD is prepended as above.
  - Undefined: no ASM word and no ASM load in IDLE. IDLE behaves like PACK with byte_cnt=0: s_axis_tready = free, and the first accepted byte enters the accumulator and moves the state to PACK. ASM_WORD is unused.

Test Plan:
- N_BYTES=255, bytes 0x00..0xFE with tlast on byte 255, m_axis_tready=1:
  - 65 words out: 0x1ACFFC1D, 0x00010203, … , 0xF8F9FAFB.
  - Final word 0xFCFDFE00, tkeep=4'hE, tlast=1.
  - No event pulses.
- Same stream with m_axis_tready at 50% random:
  - Word sequence identical to the previous case.
  - tdata/tkeep/tlast held while stalled; no byte lost or duplicated.
- tlast on byte 10 (bytes 0x00..0x09):
  - Output ASM, 0x00010203, 0x04050607, then 0x08090000 with tkeep=4'hC and tlast.
  - One evt_tlast_early pulse.
- 260 bytes with tlast on byte 260:
  - 255 bytes packed with tlast on the 64th data word; one evt_tlast_missing pulse.
  - Bytes 256–260 accepted and dropped.
  - The next frame starts with ASM and is correct.
- rst_n pulsed low after 100 bytes:
  - All outputs read 0 during reset.
  - The next frame begins with ASM; no residue from the old frame.
- Build without RS_PACK_ASM_EN, 8-byte frame with N_BYTES=8:
  - Exactly 2 words out, tkeep=4'hF, tlast on the 2nd word, no ASM word.

Source files
------------

// File: rtl/rs_word_packer.sv
// rs_word_packer
//   Packs the RS encoder's byte stream into 32-bit words for the link/DMA side.
//   The first byte of a word goes in [31:24], and tkeep is an MSB-contiguous mask.
//   A codeword frame ends on tlast or on byte N_BYTES, whichever comes first.
//   When the frame was cut short at N_BYTES, the extra input bytes are discarded
//   until the next tlast.
//
//   Build option RS_PACK_ASM_EN: when defined, ASM_WORD is sent as the first word
//   of every frame. When undefined, no sync word is sent and ASM_WORD is unused.
//
// Ports
//   core_clk, rst_n         clock, asynchronous active-low reset
//   s_axis_*                8-bit codeword byte input (tdata/tvalid/tready/tlast)
//   m_axis_*                32-bit packed word output (tdata/tkeep/tvalid/tready/tlast)
//   evt_tlast_early         1-cycle pulse: tlast arrived before byte N_BYTES
//   evt_tlast_missing       1-cycle pulse: byte N_BYTES accepted without tlast
//
// N_BYTES must be >= 1. CNT_W is derived from N_BYTES and is not meant to be overridden.
//
// state   | meaning
// IDLE    | between frames; the next frame starts here (ASM load, or first byte)
// PACK    | accepting codeword bytes into the word accumulator
// DROP    | frame already closed at N_BYTES; discarding input until tlast

module rs_word_packer #(
  parameter int unsigned N_BYTES  = 255,
  parameter logic [31:0] ASM_WORD = 32'h1ACFFC1D,
  parameter int unsigned CNT_W    = $clog2(N_BYTES + 1)
) (
  input  logic        core_clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        evt_tlast_early,
  output logic        evt_tlast_missing
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PACK = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

  logic [1:0]       state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [3:0]       out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic             evt_early_q, evt_early_d;
  logic             evt_missing_q, evt_missing_d;
  // Holds s_axis_tready low for the first cycle after reset, so every output reads 0 during reset.
  logic             run_q;

  logic        free;
  logic        s_ready;
  logic        accept;
  logic        pack_en;
  logic [31:0] word_nxt;
  logic [2:0]  fill_nxt;
  logic        at_last;
  logic        close;

`ifndef RS_PACK_ASM_EN
  logic unused_asm;
  assign unused_asm = ^ASM_WORD;
`endif

  always_comb begin
    free = !out_valid_q || m_axis_tready;

    case (state_q)
      ST_DROP: s_ready = run_q;
`ifdef RS_PACK_ASM_EN
      ST_IDLE: s_ready = 1'b0;
`else
      ST_IDLE: s_ready = run_q && free;
`endif
      default: s_ready = run_q && free;
    endcase

    accept = s_axis_tvalid && s_ready;

    case (acc_cnt_q)
      2'd0:    word_nxt = {s_axis_tdata, 24'd0};
      2'd1:    word_nxt = acc_q | {8'd0, s_axis_tdata, 16'd0};
      2'd2:    word_nxt = acc_q | {16'd0, s_axis_tdata, 8'd0};
      default: word_nxt = acc_q | {24'd0, s_axis_tdata};
    endcase

    fill_nxt = {1'b0, acc_cnt_q} + 3'd1;
    at_last  = (byte_cnt_q == LAST_IDX);
    close    = s_axis_tlast || at_last;

    state_d       = state_q;
    acc_d         = acc_q;
    acc_cnt_d     = acc_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    out_data_d    = out_data_q;
    out_keep_d    = out_keep_q;
    out_last_d    = out_last_q;
    out_valid_d   = out_valid_q && !m_axis_tready;
    evt_early_d   = 1'b0;
    evt_missing_d = 1'b0;
    pack_en       = 1'b0;

    case (state_q)
      ST_DROP: begin
        if (accept && s_axis_tlast) state_d = ST_IDLE;
      end
      ST_IDLE: begin
`ifdef RS_PACK_ASM_EN
        if (s_axis_tvalid && free && run_q) begin
          out_data_d  = ASM_WORD;
          out_keep_d  = 4'hF;
          out_last_d  = 1'b0;
          out_valid_d = 1'b1;
          acc_d       = '0;
          acc_cnt_d   = '0;
          byte_cnt_d  = '0;
          state_d     = ST_PACK;
        end
`else
        // Counters are already cleared at every frame close, so IDLE packs just like PACK.
        pack_en = 1'b1;
`endif
      end
      default: pack_en = 1'b1;
    endcase

    // accept implies free, so a completed word can always load the output register here.
    if (pack_en && accept) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
      if (close || fill_nxt[2]) begin
        out_data_d  = word_nxt;
        out_valid_d = 1'b1;
        out_last_d  = close;
        case (fill_nxt)
          3'd1:    out_keep_d = 4'h8;
          3'd2:    out_keep_d = 4'hC;
          3'd3:    out_keep_d = 4'hE;
          default: out_keep_d = 4'hF;
        endcase
        acc_d     = '0;
        acc_cnt_d = '0;
      end else begin
        acc_d     = word_nxt;
        acc_cnt_d = fill_nxt[1:0];
      end

      if (close) begin
        byte_cnt_d = '0;
        if (s_axis_tlast) begin
          state_d     = ST_IDLE;
          evt_early_d = !at_last;
        end else begin
          state_d       = ST_DROP;
          evt_missing_d = 1'b1;
        end
      end else begin
        state_d = ST_PACK;
      end
    end
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      acc_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      out_data_q    <= '0;
      out_keep_q    <= '0;
      out_last_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      evt_early_q   <= 1'b0;
      evt_missing_q <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      acc_cnt_q     <= acc_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      out_data_q    <= out_data_d;
      out_keep_q    <= out_keep_d;
      out_last_q    <= out_last_d;
      out_valid_q   <= out_valid_d;
      evt_early_q   <= evt_early_d;
      evt_missing_q <= evt_missing_d;
      run_q         <= 1'b1;
    end
  end

  assign s_axis_tready     = s_ready;
  assign m_axis_tdata      = out_data_q;
  assign m_axis_tkeep      = out_keep_q;
  assign m_axis_tvalid     = out_valid_q;
  assign m_axis_tlast      = out_last_q;
  assign evt_tlast_early   = evt_early_q;
  assign evt_tlast_missing = evt_missing_q;

endmodule

// File: tb/tb_rs_word_packer.sv
`timescale 1ns/1ps
// Two packers share one stimulus bus. Instance A has N_BYTES=255 and instance B has
// N_BYTES=8. sel picks the active instance; the idle instance sees tvalid=0 and tready=1.
module tb_rs_word_packer;

  localparam int N_A = 255;
  localparam int N_B = 8;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  logic       rst_n;
  logic       sel;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       m_tready;

  logic        a_s_tvalid, a_s_tready, a_m_tvalid, a_m_tready, a_m_tlast, a_early, a_missing;
  logic [31:0] a_m_tdata;
  logic [3:0]  a_m_tkeep;
  logic        b_s_tvalid, b_s_tready, b_m_tvalid, b_m_tready, b_m_tlast, b_early, b_missing;
  logic [31:0] b_m_tdata;
  logic [3:0]  b_m_tkeep;

  logic        o_s_tready, o_m_tvalid, o_m_tlast, o_early, o_missing;
  logic [31:0] o_m_tdata;
  logic [3:0]  o_m_tkeep;

  assign a_s_tvalid = s_tvalid && !sel;
  assign b_s_tvalid = s_tvalid && sel;
  assign a_m_tready = sel ? 1'b1 : m_tready;
  assign b_m_tready = sel ? m_tready : 1'b1;

  assign o_s_tready = sel ? b_s_tready : a_s_tready;
  assign o_m_tvalid = sel ? b_m_tvalid : a_m_tvalid;
  assign o_m_tdata  = sel ? b_m_tdata  : a_m_tdata;
  assign o_m_tkeep  = sel ? b_m_tkeep  : a_m_tkeep;
  assign o_m_tlast  = sel ? b_m_tlast  : a_m_tlast;
  assign o_early    = sel ? b_early    : a_early;
  assign o_missing  = sel ? b_missing  : a_missing;

  rs_word_packer #(.N_BYTES(N_A)) u_dut_a (
    .core_clk(core_clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tvalid(a_m_tvalid),
    .m_axis_tready(a_m_tready), .m_axis_tlast(a_m_tlast),
    .evt_tlast_early(a_early), .evt_tlast_missing(a_missing)
  );

  rs_word_packer #(.N_BYTES(N_B)) u_dut_b (
    .core_clk(core_clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
    .m_axis_tready(b_m_tready), .m_axis_tlast(b_m_tlast),
    .evt_tlast_early(b_early), .evt_tlast_missing(b_missing)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic bit rnd_pct(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // Sends one frame of len bytes (tlast on byte tpos) and checks the output against
  // a model built from the framing rules.
  task automatic run_frame(input string name, input int len, input int tpos,
                           input int ready_pct, input bit seq_data);
    logic [7:0] bytes[$];
    word_t      exp_q[$];
    word_t      e;
    int n, c, idx, exp_early, exp_missing, off_idx, exp_ev_cyc;
    int got_early, got_missing, bad_ev, stab_err, extra, done_cyc, gap;
    logic        hold, h_last, acc_now;
    logic [31:0] h_data;
    logic [3:0]  h_keep;

    n = sel ? N_B : N_A;
    for (int i = 0; i < len; i++)
      bytes.push_back(seq_data ? 8'(i) : 8'($urandom_range(255)));

`ifdef RS_PACK_ASM_EN
    e.data = 32'h1ACFFC1D; e.keep = 4'hF; e.last = 1'b0;
    exp_q.push_back(e);
`endif
    c = (tpos < n) ? tpos : n;
    for (int w = 0; w < c; w += 4) begin
      e.data = '0;
      e.keep = '0;
      for (int j = 0; j < 4; j++) begin
        if (w + j < c) begin
          e.data[31 - 8*j -: 8] = bytes[w + j];
          e.keep[3 - j] = 1'b1;
        end
      end
      e.last = (w + 4 >= c);
      exp_q.push_back(e);
    end
    exp_early   = (tpos < n) ? 1 : 0;
    exp_missing = (tpos > n) ? 1 : 0;
    off_idx     = (tpos < n) ? tpos - 1 : ((tpos > n) ? n - 1 : -1);

    exp_ev_cyc = -1; got_early = 0; got_missing = 0; bad_ev = 0;
    stab_err = 0; extra = 0; done_cyc = 0; idx = 0; hold = 1'b0;
    h_data = '0; h_keep = '0; h_last = 1'b0;
    gap = (ready_pct < 100) ? 20 : 0;

    @(posedge core_clk); #1;
    s_tvalid = 1'b1;
    s_tdata  = bytes[0];
    s_tlast  = (tpos == 1);
    m_tready = rnd_pct(ready_pct);

    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge core_clk);
      if (hold && (!o_m_tvalid || o_m_tdata !== h_data || o_m_tkeep !== h_keep ||
                   o_m_tlast !== h_last))
        stab_err++;
      if (o_early) begin
        got_early++;
        if (exp_early == 0 || cyc != exp_ev_cyc) bad_ev++;
      end
      if (o_missing) begin
        got_missing++;
        if (exp_missing == 0 || cyc != exp_ev_cyc) bad_ev++;
      end
      if (o_m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (o_m_tdata !== e.data || o_m_tkeep !== e.keep || o_m_tlast !== e.last)
            $display("FAIL %s word: got %h/%h/%b, expected %h/%h/%b", name,
                     o_m_tdata, o_m_tkeep, o_m_tlast, e.data, e.keep, e.last);
          else
            n_pass++;
        end
      end
      hold   = o_m_tvalid && !m_tready;
      h_data = o_m_tdata;
      h_keep = o_m_tkeep;
      h_last = o_m_tlast;
      acc_now = s_tvalid && o_s_tready;
      if (acc_now) begin
        if (idx == off_idx) exp_ev_cyc = cyc + 1;
        idx++;
      end
      if (idx >= len && exp_q.size() == 0) done_cyc++;
      if (done_cyc > 4) break;

      @(posedge core_clk); #1;
      m_tready = rnd_pct(ready_pct);
      if (idx < len) begin
        if (!(s_tvalid && !acc_now)) s_tvalid = !rnd_pct(gap);
        s_tdata = bytes[idx];
        s_tlast = (idx == tpos - 1);
      end else begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    n_checks++;
    if (idx != len || exp_q.size() != 0)
      $display("FAIL %s completion: got %0d bytes, %0d words outstanding, expected %0d bytes, 0 outstanding",
               name, idx, exp_q.size(), len);
    else n_pass++;
    n_checks++;
    if (extra != 0) $display("FAIL %s extra_words: got %0d, expected 0", name, extra);
    else n_pass++;
    n_checks++;
    if (got_early != exp_early)
      $display("FAIL %s evt_early_count: got %0d, expected %0d", name, got_early, exp_early);
    else n_pass++;
    n_checks++;
    if (got_missing != exp_missing)
      $display("FAIL %s evt_missing_count: got %0d, expected %0d", name, got_missing, exp_missing);
    else n_pass++;
    n_checks++;
    if (bad_ev != 0) $display("FAIL %s evt_timing: got %0d misplaced pulses, expected 0", name, bad_ev);
    else n_pass++;
    n_checks++;
    if (stab_err != 0) $display("FAIL %s stall_hold: got %0d changes under stall, expected 0", name, stab_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    n_checks++;
    if ({a_s_tready, a_m_tvalid, a_m_tdata, a_m_tkeep, a_m_tlast, a_early, a_missing} !== 40'd0)
      $display("FAIL reset_a outputs: got %h, expected 0",
               {a_s_tready, a_m_tvalid, a_m_tdata, a_m_tkeep, a_m_tlast, a_early, a_missing});
    else n_pass++;
    n_checks++;
    if ({b_s_tready, b_m_tvalid, b_m_tdata, b_m_tkeep, b_m_tlast, b_early, b_missing} !== 40'd0)
      $display("FAIL reset_b outputs: got %h, expected 0",
               {b_s_tready, b_m_tvalid, b_m_tdata, b_m_tkeep, b_m_tlast, b_early, b_missing});
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(posedge core_clk);
  endtask

  task automatic test_full_frame();
    sel = 1'b0;
    run_frame("full255", 255, 255, 100, 1'b1);
  endtask

  task automatic test_stall();
    sel = 1'b0;
    run_frame("stall255", 255, 255, 50, 1'b1);
  endtask

  task automatic test_tlast_early();
    sel = 1'b0;
    run_frame("early10", 10, 10, 100, 1'b1);
  endtask

  task automatic test_tlast_missing();
    sel = 1'b0;
    run_frame("missing260", 260, 260, 100, 1'b1);
    run_frame("after_drop", 255, 255, 70, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int cnt;
    sel = 1'b0;
    m_tready = 1'b1;
    cnt = 0;
    @(posedge core_clk); #1;
    s_tvalid = 1'b1; s_tdata = 8'h00; s_tlast = 1'b0;
    for (int cyc = 0; cyc < 1000 && cnt < 100; cyc++) begin
      @(negedge core_clk);
      if (s_tvalid && o_s_tready) cnt++;
      @(posedge core_clk); #1;
      s_tdata = 8'(cnt);
    end
    s_tvalid = 1'b0;
    n_checks++;
    if (cnt != 100) $display("FAIL midreset_feed: got %0d bytes, expected 100", cnt);
    else n_pass++;
    @(negedge core_clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_s_tready, a_m_tvalid, a_m_tdata, a_m_tkeep, a_m_tlast, a_early, a_missing} !== 40'd0)
      $display("FAIL midreset outputs: got %h, expected 0",
               {a_s_tready, a_m_tvalid, a_m_tdata, a_m_tkeep, a_m_tlast, a_early, a_missing});
    else n_pass++;
    repeat (2) @(negedge core_clk);
    rst_n = 1'b1;
    run_frame("after_reset", 255, 255, 100, 1'b1);
  endtask

  task automatic test_small_n();
    sel = 1'b1;
    run_frame("n8_exact", 8, 8, 100, 1'b1);
    run_frame("n8_one_byte", 1, 1, 100, 1'b0);
    run_frame("n8_missing", 11, 11, 60, 1'b0);
    run_frame("n8_seven", 7, 7, 50, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    int n, len;
    for (int f = 0; f < 8; f++) begin
      sel = 1'(f % 2);
      n   = sel ? N_B : N_A;
      len = int'($urandom_range(1, n + 6));
      run_frame("random", len, len, int'($urandom_range(30, 100)), 1'b0);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    sel      = 1'b0;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    test_reset();
    test_full_frame();
    test_stall();
    test_tlast_early();
    test_tlast_missing();
    test_reset_midframe();
    test_small_n();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
